// File: rtl/id_stage_pipelined_if.sv
// rtl/id_stage_pipelined_if.sv - IF/ID-side, write-back, hazard and ID/EX bundle for the decode stage
//
// Purpose : groups every non-clock/reset signal of id_stage_pipelined.
// master  : upstream/environment side; drives the IF/ID instruction, write-back,
//           EX-stage load info and flush; observes stall and the ID/EX register.
// slave   : the decode stage itself.
// Signals :
//   valid, pc, instruction         IF/ID entry (pc is PC+4)
//   wb_write, wb_addr, wb_data     write-back port into the register file
//   ex_mem_read, ex_rt             load currently in EX and its destination
//   flush                          squash the instruction entering EX
//   stall                          combinational load-use stall request
//   idex_*                         registered ID/EX pipeline outputs

interface id_stage_pipelined_if #(
    parameter int NB_ADDR = 32,
    parameter int NB_INST = 32,
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
);
    logic                valid;
    logic [NB_ADDR-1:0]  pc;
    logic [NB_INST-1:0]  instruction;
    logic                wb_write;
    logic [NB_REG-1:0]   wb_addr;
    logic [NB_DATA-1:0]  wb_data;
    logic                ex_mem_read;
    logic [NB_REG-1:0]   ex_rt;
    logic                flush;

    logic                stall;
    logic                idex_valid;
    logic [NB_ADDR-1:0]  idex_pc;
    logic [NB_DATA-1:0]  idex_data_1;
    logic [NB_DATA-1:0]  idex_data_2;
    logic [NB_DATA-1:0]  idex_sign_extend;
    logic [NB_REG-1:0]   idex_rs;
    logic [NB_REG-1:0]   idex_rt;
    logic [NB_REG-1:0]   idex_rd;
    logic [5:0]          idex_opcode;
    logic [5:0]          idex_funct;
    logic                idex_reg_dst;
    logic                idex_alu_src;
    logic                idex_mem_read;
    logic                idex_mem_write;
    logic                idex_reg_write;
    logic                idex_mem_to_reg;

    modport master (
        output valid, pc, instruction, wb_write, wb_addr, wb_data,
               ex_mem_read, ex_rt, flush,
        input  stall, idex_valid, idex_pc, idex_data_1, idex_data_2,
               idex_sign_extend, idex_rs, idex_rt, idex_rd, idex_opcode,
               idex_funct, idex_reg_dst, idex_alu_src, idex_mem_read,
               idex_mem_write, idex_reg_write, idex_mem_to_reg
    );

    modport slave (
        input  valid, pc, instruction, wb_write, wb_addr, wb_data,
               ex_mem_read, ex_rt, flush,
        output stall, idex_valid, idex_pc, idex_data_1, idex_data_2,
               idex_sign_extend, idex_rs, idex_rt, idex_rd, idex_opcode,
               idex_funct, idex_reg_dst, idex_alu_src, idex_mem_read,
               idex_mem_write, idex_reg_write, idex_mem_to_reg
    );
endinterface

// File: rtl/id_stage_pipelined.sv
// rtl/id_stage_pipelined.sv - MIPS instruction-decode stage with register file, hazard detect and ID/EX register
//
// Purpose : decodes the IF/ID instruction, reads a resettable register file with
//           write-through bypass from write-back, extends the immediate by opcode
//           class, generates main control, detects load-use hazards and loads the
//           ID/EX register (bubble on flush, stall or invalid input).
// Ports   :
//   i_clk    rising-edge clock
//   i_reset  asynchronous active-high reset; clears ID/EX and the register file
//   bus      id_stage_pipelined_if.slave (see the interface file for members)

module id_stage_pipelined #(
    parameter int NB_ADDR      = 32,
    parameter int NB_INST      = 32,
    parameter int NB_DATA      = 32,
    parameter int NB_REG       = 5,
    parameter int NB_IMMEDIATE = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    id_stage_pipelined_if.slave    bus
);

    localparam int N_REGS = 2 ** NB_REG;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic [5:0]              opcode;
    logic [5:0]              funct;
    logic [NB_REG-1:0]       rs;
    logic [NB_REG-1:0]       rt;
    logic [NB_REG-1:0]       rd;
    logic [NB_IMMEDIATE-1:0] imm;

    assign opcode = bus.instruction[31:26];
    assign rs     = bus.instruction[21 +: NB_REG];
    assign rt     = bus.instruction[16 +: NB_REG];
    assign rd     = bus.instruction[11 +: NB_REG];
    assign funct  = bus.instruction[5:0];
    assign imm    = bus.instruction[NB_IMMEDIATE-1:0];

    // ------------------------------------------------------------------
    // Register file (entry 0 is never written and always reads 0)
    // ------------------------------------------------------------------
    logic [NB_DATA-1:0] regs [N_REGS];
    logic               wb_active;

    assign wb_active = bus.wb_write && (bus.wb_addr != '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_active) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Write-through: a same-cycle write-back to the read index wins over the
    // stored value so the instruction sees the result being retired now.
    logic [NB_DATA-1:0] rs_data;
    logic [NB_DATA-1:0] rt_data;

    always_comb begin
        rs_data = regs[rs];
        if (rs == '0) begin
            rs_data = '0;
        end else if (wb_active && (bus.wb_addr == rs)) begin
            rs_data = bus.wb_data;
        end
    end

    always_comb begin
        rt_data = regs[rt];
        if (rt == '0) begin
            rt_data = '0;
        end else if (wb_active && (bus.wb_addr == rt)) begin
            rt_data = bus.wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Immediate extension
    // ------------------------------------------------------------------
    logic [NB_DATA-1:0] ext_imm;

    always_comb begin
        ext_imm = {{(NB_DATA-NB_IMMEDIATE){imm[NB_IMMEDIATE-1]}}, imm};
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: ext_imm = {{(NB_DATA-NB_IMMEDIATE){1'b0}}, imm};
            OP_LUI:                   ext_imm = {imm, {(NB_DATA-NB_IMMEDIATE){1'b0}}};
            default:                  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Main control
    // ------------------------------------------------------------------
    logic c_reg_dst;
    logic c_alu_src;
    logic c_mem_read;
    logic c_mem_write;
    logic c_reg_write;
    logic c_mem_to_reg;
    logic uses_rt;

    always_comb begin
        c_reg_dst    = 1'b0;
        c_alu_src    = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_write  = 1'b0;
        c_reg_write  = 1'b0;
        c_mem_to_reg = 1'b0;
        uses_rt      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                c_reg_dst   = 1'b1;
                c_reg_write = 1'b1;
                uses_rt     = 1'b1;
            end
            OP_LW: begin
                c_alu_src    = 1'b1;
                c_mem_read   = 1'b1;
                c_mem_to_reg = 1'b1;
                c_reg_write  = 1'b1;
            end
            OP_SW: begin
                c_alu_src   = 1'b1;
                c_mem_write = 1'b1;
                uses_rt     = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                c_alu_src   = 1'b1;
                c_reg_write = 1'b1;
            end
            // Branches compare rs with rt but write nothing; control is
            // resolved elsewhere.
            OP_BEQ, OP_BNE: begin
                uses_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Load-use hazard: rt only counts when the instruction reads it, so an
    // I-type whose rt is its destination does not stall falsely.
    // ------------------------------------------------------------------
    assign bus.stall = bus.valid && bus.ex_mem_read && (bus.ex_rt != '0) &&
                       ((bus.ex_rt == rs) || ((bus.ex_rt == rt) && uses_rt));

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    logic bubble;

    assign bubble = bus.flush || bus.stall || !bus.valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || bubble) begin
            bus.idex_valid       <= 1'b0;
            bus.idex_pc          <= '0;
            bus.idex_data_1      <= '0;
            bus.idex_data_2      <= '0;
            bus.idex_sign_extend <= '0;
            bus.idex_rs          <= '0;
            bus.idex_rt          <= '0;
            bus.idex_rd          <= '0;
            bus.idex_opcode      <= '0;
            bus.idex_funct       <= '0;
            bus.idex_reg_dst     <= 1'b0;
            bus.idex_alu_src     <= 1'b0;
            bus.idex_mem_read    <= 1'b0;
            bus.idex_mem_write   <= 1'b0;
            bus.idex_reg_write   <= 1'b0;
            bus.idex_mem_to_reg  <= 1'b0;
        end else begin
            bus.idex_valid       <= 1'b1;
            bus.idex_pc          <= bus.pc;
            bus.idex_data_1      <= rs_data;
            bus.idex_data_2      <= rt_data;
            bus.idex_sign_extend <= ext_imm;
            bus.idex_rs          <= rs;
            bus.idex_rt          <= rt;
            bus.idex_rd          <= rd;
            bus.idex_opcode      <= opcode;
            bus.idex_funct       <= funct;
            bus.idex_reg_dst     <= c_reg_dst;
            bus.idex_alu_src     <= c_alu_src;
            bus.idex_mem_read    <= c_mem_read;
            bus.idex_mem_write   <= c_mem_write;
            bus.idex_reg_write   <= c_reg_write;
            bus.idex_mem_to_reg  <= c_mem_to_reg;
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb/tb_id_stage_pipelined.sv - randomized self-checking bench for id_stage_pipelined

module tb_id_stage_pipelined;

    localparam int NB_ADDR = 32;
    localparam int NB_INST = 32;
    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    id_stage_pipelined_if #(
        .NB_ADDR(NB_ADDR), .NB_INST(NB_INST), .NB_DATA(NB_DATA), .NB_REG(NB_REG)
    ) bus ();

    id_stage_pipelined #(
        .NB_ADDR(NB_ADDR), .NB_INST(NB_INST), .NB_DATA(NB_DATA),
        .NB_REG(NB_REG), .NB_IMMEDIATE(16)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_regs [32];

    logic        e_valid, e_reg_dst, e_alu_src, e_mem_read, e_mem_write, e_reg_write, e_mem_to_reg;
    logic [31:0] e_pc, e_data_1, e_data_2, e_ext;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic [5:0]  e_opcode, e_funct;
    logic        last_stall;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        logic [31:0] w;
        w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
        return w;
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        logic [31:0] w;
        w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm & 16'hFFFF);
        return w;
    endfunction

    // Reference read: r0 is zero, a live write-back to the index is seen now.
    function automatic logic [31:0] m_read(input int idx);
        if (idx == 0) return 32'h0;
        if (bus.wb_write && int'(bus.wb_addr) == idx) return bus.wb_data;
        return m_regs[idx];
    endfunction

    task automatic clear_expected();
        {e_valid, e_reg_dst, e_alu_src, e_mem_read, e_mem_write, e_reg_write, e_mem_to_reg} = '0;
        {e_pc, e_data_1, e_data_2, e_ext} = '0;
        {e_rs, e_rt, e_rd, e_opcode, e_funct} = '0;
    endtask

    task automatic check_outputs(input string tag);
        check_value({tag, ".valid"}, bus.idex_valid, e_valid);
        check_value({tag, ".pc"}, bus.idex_pc, e_pc);
        check_value({tag, ".data_1"}, bus.idex_data_1, e_data_1);
        check_value({tag, ".data_2"}, bus.idex_data_2, e_data_2);
        check_value({tag, ".ext"}, bus.idex_sign_extend, e_ext);
        check_value({tag, ".rs"}, bus.idex_rs, e_rs);
        check_value({tag, ".rt"}, bus.idex_rt, e_rt);
        check_value({tag, ".rd"}, bus.idex_rd, e_rd);
        check_value({tag, ".opcode"}, bus.idex_opcode, e_opcode);
        check_value({tag, ".funct"}, bus.idex_funct, e_funct);
        check_value({tag, ".reg_dst"}, bus.idex_reg_dst, e_reg_dst);
        check_value({tag, ".alu_src"}, bus.idex_alu_src, e_alu_src);
        check_value({tag, ".mem_read"}, bus.idex_mem_read, e_mem_read);
        check_value({tag, ".mem_write"}, bus.idex_mem_write, e_mem_write);
        check_value({tag, ".reg_write"}, bus.idex_reg_write, e_reg_write);
        check_value({tag, ".mem_to_reg"}, bus.idex_mem_to_reg, e_mem_to_reg);
    endtask

    // Inputs are already driven; settle, check stall, predict ID/EX, clock, check.
    task automatic cycle(input string tag);
        int op, rs, rt, imm;
        bit uses_rt, exp_stall;
        logic [31:0] z;
        #1;
        op  = int'(bus.instruction[31:26]);
        rs  = int'(bus.instruction[25:21]);
        rt  = int'(bus.instruction[20:16]);
        imm = int'(bus.instruction[15:0]);
        uses_rt = (op == 'h00) || (op == 'h2B) || (op == 'h04) || (op == 'h05);
        exp_stall = bus.valid && bus.ex_mem_read && (bus.ex_rt != 0) &&
                    ((int'(bus.ex_rt) == rs) || (int'(bus.ex_rt) == rt && uses_rt));
        last_stall = bus.stall;
        check_value({tag, ".stall"}, bus.stall, exp_stall);

        clear_expected();
        if (!(bus.flush || exp_stall || !bus.valid)) begin
            e_valid  = 1'b1;
            e_pc     = bus.pc;
            e_data_1 = m_read(rs);
            e_data_2 = m_read(rt);
            z = 32'(imm);
            if (op == 'h0C || op == 'h0D || op == 'h0E) e_ext = z;
            else if (op == 'h0F) e_ext = z * 32'd65536;
            else if (imm >= 'h8000) e_ext = z - 32'h10000;
            else e_ext = z;
            e_rs = 5'(rs); e_rt = 5'(rt); e_rd = bus.instruction[15:11];
            e_opcode = 6'(op); e_funct = bus.instruction[5:0];
            e_reg_dst    = (op == 'h00);
            e_mem_read   = (op == 'h23);
            e_mem_to_reg = (op == 'h23);
            e_mem_write  = (op == 'h2B);
            e_alu_src    = (op == 'h23) || (op == 'h2B) || (op == 'h08) || (op >= 'h0C && op <= 'h0F);
            e_reg_write  = (op == 'h00) || (op == 'h23) || (op == 'h08) || (op >= 'h0C && op <= 'h0F);
        end

        @(posedge clk);
        if (bus.wb_write && bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        bus.valid       = 1'b1;
        bus.pc          = $urandom;
        bus.instruction = 32'h0;
        bus.wb_write    = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rt       = '0;
        bus.flush       = 1'b0;
    endtask

    logic [5:0] op_pool [10] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h05};

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        idle_inputs();
        rst = 1'b1;
        #2;
        clear_expected();
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Preload r5, then assert reset mid-cycle.
        idle_inputs();
        bus.wb_write = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
        bus.instruction = rtype(5, 0, 3, 'h20);
        cycle("preload");
        check_value("preload.bypass", bus.idex_data_1, 32'h1234);
        idle_inputs();
        #3;
        rst = 1'b1;
        #1;
        clear_expected();
        check_outputs("mid_reset");
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        bus.instruction = rtype(5, 6, 3, 'h20);
        cycle("post_reset");
        check_value("post_reset.r5", bus.idex_data_1, 32'h0);
        check_value("post_reset.valid", bus.idex_valid, 1'b1);

        // Write-back bypass.
        idle_inputs();
        bus.wb_write = 1'b1; bus.wb_addr = 5'd8; bus.wb_data = 32'hDEADBEEF;
        bus.instruction = rtype(8, 9, 3, 'h20);
        cycle("bypass");
        check_value("bypass.data_1", bus.idex_data_1, 32'hDEADBEEF);
        check_value("bypass.reg_dst", bus.idex_reg_dst, 1'b1);
        check_value("bypass.reg_write", bus.idex_reg_write, 1'b1);
        idle_inputs();
        bus.instruction = rtype(8, 0, 3, 'h20);
        cycle("stored");
        check_value("stored.data_1", bus.idex_data_1, 32'hDEADBEEF);

        // r0 is never written.
        idle_inputs();
        bus.wb_write = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h55;
        bus.instruction = rtype(0, 0, 1, 'h20);
        cycle("r0_write");
        idle_inputs();
        bus.instruction = rtype(0, 0, 1, 'h20);
        cycle("r0_read");
        check_value("r0_read.data_1", bus.idex_data_1, 32'h0);
        check_value("r0_read.data_2", bus.idex_data_2, 32'h0);

        // Immediate extension.
        idle_inputs(); bus.instruction = itype('h08, 2, 3, 'hFFF0); cycle("addi");
        check_value("addi.ext", bus.idex_sign_extend, 32'hFFFFFFF0);
        idle_inputs(); bus.instruction = itype('h0D, 2, 3, 'hFFF0); cycle("ori");
        check_value("ori.ext", bus.idex_sign_extend, 32'h0000FFF0);
        idle_inputs(); bus.instruction = itype('h0F, 0, 3, 'h1234); cycle("lui");
        check_value("lui.ext", bus.idex_sign_extend, 32'h12340000);

        // Load-use stall then re-present.
        idle_inputs();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd4;
        bus.instruction = itype('h2B, 2, 4, 0);
        cycle("lu_stall");
        check_value("lu_stall.o_stall", last_stall, 1'b1);
        check_value("lu_stall.valid", bus.idex_valid, 1'b0);
        check_value("lu_stall.mem_write", bus.idex_mem_write, 1'b0);
        bus.ex_mem_read = 1'b0;
        cycle("lu_resume");
        check_value("lu_resume.o_stall", last_stall, 1'b0);
        check_value("lu_resume.mem_write", bus.idex_mem_write, 1'b1);

        // No false stalls.
        idle_inputs();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd4;
        bus.instruction = itype('h08, 2, 4, 1);
        cycle("nostall_dst");
        check_value("nostall_dst.o_stall", last_stall, 1'b0);
        bus.ex_rt = 5'd0;
        bus.instruction = rtype(0, 0, 7, 'h20);
        cycle("nostall_r0");
        check_value("nostall_r0.o_stall", last_stall, 1'b0);

        // Flush, alone and together with a stall.
        idle_inputs();
        bus.flush = 1'b1;
        bus.instruction = itype('h23, 1, 2, 4);
        cycle("flush");
        check_value("flush.valid", bus.idex_valid, 1'b0);
        check_value("flush.mem_read", bus.idex_mem_read, 1'b0);
        check_value("flush.reg_write", bus.idex_reg_write, 1'b0);
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd1;
        cycle("flush_stall");
        check_value("flush_stall.o_stall", last_stall, 1'b1);
        check_value("flush_stall.valid", bus.idex_valid, 1'b0);

        // Randomized traffic on a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            int k;
            logic [5:0] op;
            k  = int'($urandom_range(0, 10));
            if (k == 10) op = 6'($urandom_range(0, 63));
            else op = op_pool[k];
            bus.valid       = ($urandom_range(0, 9) != 0);
            bus.pc          = $urandom;
            bus.instruction = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                               16'($urandom)};
            bus.wb_write    = $urandom_range(0, 1) == 1;
            bus.wb_addr     = 5'($urandom_range(0, 7));
            bus.wb_data     = $urandom;
            bus.ex_mem_read = $urandom_range(0, 2) == 0;
            bus.ex_rt       = 5'($urandom_range(0, 7));
            bus.flush       = $urandom_range(0, 7) == 0;
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
